// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if
//   Handshake bundle for the immediate-extension stage.
//   Request side : in_valid, in_ready, in_mode, in_imm, in_tag
//   Result side  : out_valid, out_ready, out_imm, out_tag, out_err
//   slave  modport : the extension stage (consumes requests, produces results)
//   master modport : the surrounding pipeline (issues requests, consumes results)
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_mode;
    logic [IN_W-1:0]  in_imm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport slave (
        input  in_valid, in_mode, in_imm, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport master (
        output in_valid, in_mode, in_imm, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe
//   Registered immediate-extension stage with a one-entry skid buffer.
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     flush    synchronous flush: empties the stage, drops the offered input
//     bus      imm_ext_pipe_if.slave handshake bundle (requests in, results out)
//     err_cnt  saturating count of accepted reserved-mode (6/7) requests
//   Modes: 0 zext, 1 sext, 2 upper placement, 3 sext << BR_SHIFT,
//          4 sext of low byte, 5 zext of low byte, 6/7 reserved (0 with error).
module imm_ext_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    imm_ext_pipe_if.slave       bus,
    output logic [7:0]          err_cnt
);

    // Compute the extended operand for one request.
    function automatic logic [OUT_W-1:0] ext_imm(input logic [2:0] mode,
                                                 input logic [IN_W-1:0] imm);
        logic [OUT_W-1:0] zx;
        logic [OUT_W-1:0] sx;
        logic [OUT_W-1:0] up;
        logic [OUT_W-1:0] zb;
        logic [OUT_W-1:0] sb;
        logic [OUT_W-1:0] res;
        zx = '0;
        zx[IN_W-1:0] = imm;
        sx = {OUT_W{imm[IN_W-1]}};
        sx[IN_W-1:0] = imm;
        up = '0;
        up[OUT_W-1 -: IN_W] = imm;
        zb = '0;
        zb[7:0] = imm[7:0];
        sb = {OUT_W{imm[7]}};
        sb[7:0] = imm[7:0];
        case (mode)
            3'd0:    res = zx;
            3'd1:    res = sx;
            3'd2:    res = up;
            3'd3:    res = sx << BR_SHIFT;
            3'd4:    res = sb;
            3'd5:    res = zb;
            default: res = '0;
        endcase
        return res;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_imm_q,   out_imm_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;
    logic             out_err_q,   out_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_imm_q,   skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic             skid_err_q,   skid_err_d;
    logic [7:0]       err_cnt_q,    err_cnt_d;

    logic             accept_s;
    logic [OUT_W-1:0] result_s;
    logic             res_err_s;

    // Next-state logic for the output register, skid entry and error counter.
    always_comb begin
        accept_s  = bus.in_valid & ~skid_valid_q & ~flush;
        result_s  = ext_imm(bus.in_mode, bus.in_imm);
        res_err_s = bus.in_mode[2] & bus.in_mode[1];

        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            // Output slot frees up this cycle; the skid entry is older than
            // any new request, so it has priority. in_ready is low while the
            // skid is full, so no accept can collide with the move.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d = 1'b1;
                out_imm_d   = result_s;
                out_tag_d   = bus.in_tag;
                out_err_d   = res_err_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            // Output is stalled: a new request parks in the skid entry.
            if (accept_s) begin
                skid_valid_d = 1'b1;
                skid_imm_d   = result_s;
                skid_tag_d   = bus.in_tag;
                skid_err_d   = res_err_s;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end

        if (accept_s && res_err_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // in_ready depends only on registered state.
    assign bus.in_ready  = ~skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush;
    logic [7:0] err_cnt;
    logic [7:0] b_err_cnt;
    logic b_flush;

    always #5 clk = ~clk;

    imm_ext_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) a_if ();
    imm_ext_pipe_if #(.IN_W(12), .OUT_W(64), .TAG_W(5)) b_if ();

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2), .TAG_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(a_if.slave), .err_cnt(err_cnt)
    );

    imm_ext_pipe #(.IN_W(12), .OUT_W(64), .BR_SHIFT(4), .TAG_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .bus(b_if.slave), .err_cnt(b_err_cnt)
    );

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    // Spec-level extension rule using plain integer arithmetic.
    function automatic logic [63:0] ext_model(input int mode, input logic [63:0] imm,
                                              input int in_w, input int out_w, input int sh);
        logic [63:0] mask;
        logic [63:0] u;
        longint      s_val;
        longint      b;
        longint      sb;
        longint      r;
        mask  = (out_w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << out_w) - 64'd1);
        u     = imm & ((64'd1 << in_w) - 64'd1);
        s_val = u[in_w-1] ? (longint'(u) - (longint'(1) << in_w)) : longint'(u);
        b     = longint'(imm & 64'hFF);
        sb    = (b >= 128) ? (b - 256) : b;
        case (mode)
            0:       r = longint'(u);
            1:       r = s_val;
            2:       r = longint'(u) * (longint'(1) << (out_w - in_w));
            3:       r = s_val * (longint'(1) << sh);
            4:       r = sb;
            5:       r = b;
            default: r = 0;
        endcase
        return 64'(r) & mask;
    endfunction

    // Scoreboard state
    exp_t q[$];
    exp_t bq[$];
    int   em;

    // Hand-computed literal expectations, keyed by tag
    bit          lit_valid [32];
    logic [63:0] lit_imm   [32];
    bit          b_lit_valid [32];
    logic [63:0] b_lit_imm   [32];
    bit          lit_rdy_en;
    logic        lit_rdy_val;
    bit          lit_ecnt_en;
    logic [7:0]  lit_ecnt_val;
    int          tmo_events;

    int vectors;
    int miscompares;
    int tmo_seen;

    // Model update: mirrors transfers as seen at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            bq.delete();
            em = 0;
        end else begin
            bit   acc;
            exp_t e;
            acc = a_if.in_valid && (q.size() < 2) && !flush;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && a_if.out_ready) void'(q.pop_front());
                if (acc) begin
                    e.imm = ext_model(int'(a_if.in_mode), 64'(a_if.in_imm), 16, 32, 2);
                    e.tag = a_if.in_tag;
                    e.err = (a_if.in_mode >= 3'd6);
                    q.push_back(e);
                    if (e.err && em < 255) em = em + 1;
                end
            end
            if (bq.size() > 0) void'(bq.pop_front());
            if (b_if.in_valid) begin
                e.imm = ext_model(int'(b_if.in_mode), 64'(b_if.in_imm), 12, 64, 4);
                e.tag = b_if.in_tag;
                e.err = (b_if.in_mode >= 3'd6);
                bq.push_back(e);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: checks DUT outputs against the model every falling edge.
    always @(negedge clk) begin
        if (tmo_events != tmo_seen) begin
            vectors     = vectors + 1;
            miscompares = miscompares + (tmo_events - tmo_seen);
            tmo_seen    = tmo_events;
        end
        if (!rst_n) begin
            chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
            chk("rst_in_ready",  64'(a_if.in_ready),  64'd1);
            chk("rst_out_imm",   64'(a_if.out_imm),   64'd0);
            chk("rst_out_tag",   64'(a_if.out_tag),   64'd0);
            chk("rst_out_err",   64'(a_if.out_err),   64'd0);
            chk("rst_err_cnt",   64'(err_cnt),        64'd0);
            chk("rst_b_valid",   64'(b_if.out_valid), 64'd0);
        end else begin
            chk("out_valid", 64'(a_if.out_valid), 64'(q.size() > 0));
            chk("in_ready",  64'(a_if.in_ready),  64'(q.size() < 2));
            chk("err_cnt",   64'(err_cnt),        64'(em));
            if (q.size() > 0) begin
                chk("out_imm", 64'(a_if.out_imm), q[0].imm);
                chk("out_tag", 64'(a_if.out_tag), 64'(q[0].tag));
                chk("out_err", 64'(a_if.out_err), 64'(q[0].err));
                if (lit_valid[q[0].tag]) begin
                    chk("lit_out_imm",   64'(a_if.out_imm), lit_imm[q[0].tag]);
                    chk("lit_model_imm", q[0].imm,          lit_imm[q[0].tag]);
                end
            end
            if (lit_rdy_en)  chk("lit_in_ready", 64'(a_if.in_ready), 64'(lit_rdy_val));
            if (lit_ecnt_en) chk("lit_err_cnt",  64'(err_cnt),       64'(lit_ecnt_val));
            chk("b_out_valid", 64'(b_if.out_valid), 64'(bq.size() > 0));
            if (bq.size() > 0) begin
                chk("b_out_imm", b_if.out_imm,       bq[0].imm);
                chk("b_out_tag", 64'(b_if.out_tag),  64'(bq[0].tag));
                if (b_lit_valid[bq[0].tag]) begin
                    chk("b_lit_out_imm",   b_if.out_imm, b_lit_imm[bq[0].tag]);
                    chk("b_lit_model_imm", bq[0].imm,    b_lit_imm[bq[0].tag]);
                end
            end
        end
    end

    // Offer one request on side A and hold it until accepted (bounded).
    task automatic send(input logic [2:0] m, input logic [15:0] imm, input logic [4:0] tag);
        bit ok;
        int n;
        a_if.in_valid = 1'b1;
        a_if.in_mode  = m;
        a_if.in_imm   = imm;
        a_if.in_tag   = tag;
        n = 0;
        forever begin
            @(negedge clk);
            ok = a_if.in_ready && !flush;
            @(posedge clk);
            #1;
            if (ok) break;
            n = n + 1;
            if (n > 200) begin
                $display("FAIL send_timeout: tag %0d not accepted, expected accept within 200 cycles", tag);
                tmo_events = tmo_events + 1;
                break;
            end
        end
        a_if.in_valid = 1'b0;
    endtask

    task automatic send_lit(input logic [2:0] m, input logic [15:0] imm, input logic [4:0] tag,
                            input logic [63:0] exp);
        lit_valid[tag] = 1'b1;
        lit_imm[tag]   = exp;
        send(m, imm, tag);
    endtask

    initial begin
        vectors = 0; miscompares = 0; tmo_events = 0; tmo_seen = 0;
        lit_rdy_en = 1'b0; lit_rdy_val = 1'b0; lit_ecnt_en = 1'b0; lit_ecnt_val = 8'd0;
        for (int i = 0; i < 32; i++) begin
            lit_valid[i] = 1'b0; lit_imm[i] = 64'd0;
            b_lit_valid[i] = 1'b0; b_lit_imm[i] = 64'd0;
        end
        flush = 1'b0; b_flush = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_mode = 3'd0; a_if.in_imm = 16'd0; a_if.in_tag = 5'd0;
        a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_mode = 3'd0; b_if.in_imm = 12'd0; b_if.in_tag = 5'd0;
        b_if.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single requests, one idle cycle apart
        send_lit(3'd0, 16'h8001, 5'd20, 64'h0000_8001); @(posedge clk); #1;
        send_lit(3'd1, 16'h8001, 5'd21, 64'hFFFF_8001); @(posedge clk); #1;
        send_lit(3'd2, 16'h1234, 5'd22, 64'h1234_0000); @(posedge clk); #1;
        send_lit(3'd3, 16'h8001, 5'd23, 64'hFFFE_0004); @(posedge clk); #1;
        send_lit(3'd4, 16'h1280, 5'd24, 64'hFFFF_FF80); @(posedge clk); #1;
        send_lit(3'd5, 16'h1280, 5'd25, 64'h0000_0080); @(posedge clk); #1;

        // Back-pressure: two held, third waits upstream
        a_if.out_ready = 1'b0;
        send_lit(3'd1, 16'h00F0, 5'd1, 64'h0000_00F0);
        send_lit(3'd2, 16'h0001, 5'd2, 64'h0001_0000);
        lit_rdy_en = 1'b1; lit_rdy_val = 1'b0;
        fork
            send_lit(3'd5, 16'hFFFF, 5'd3, 64'h0000_00FF);
            begin
                repeat (3) @(posedge clk);
                #1 lit_rdy_en = 1'b0;
                a_if.out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;

        // Flush with both entries full and a request offered
        a_if.out_ready = 1'b0;
        send(3'd0, 16'h0004, 5'd4);
        send(3'd0, 16'h0005, 5'd5);
        a_if.in_valid = 1'b1; a_if.in_mode = 3'd0; a_if.in_imm = 16'h0006; a_if.in_tag = 5'd6;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
        lit_rdy_en = 1'b1; lit_rdy_val = 1'b1;
        @(posedge clk); #1;
        lit_rdy_en = 1'b0;
        // Flush on an empty stage discards a reserved-mode request
        a_if.in_valid = 1'b1; a_if.in_mode = 3'd6; a_if.in_imm = 16'h0007; a_if.in_tag = 5'd7;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; a_if.in_valid = 1'b0;
        lit_ecnt_en = 1'b1; lit_ecnt_val = 8'd0;
        @(posedge clk); #1;
        lit_ecnt_en = 1'b0;

        // Reserved modes: counter saturates
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 0) ? 3'd6 : 3'd7, 16'($urandom_range(0, 65535)), 5'(8 + (i % 8)));
        end
        send_lit(3'd7, 16'hFFFF, 5'd27, 64'd0);
        repeat (2) @(posedge clk); #1;
        lit_ecnt_en = 1'b1; lit_ecnt_val = 8'd255;
        @(posedge clk); #1;
        lit_ecnt_en = 1'b0;

        // Asynchronous reset during streaming
        a_if.in_valid = 1'b1; a_if.in_mode = 3'd0; a_if.in_imm = 16'h0042; a_if.in_tag = 5'd16;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        a_if.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send_lit(3'd1, 16'h7FFF, 5'd28, 64'h0000_7FFF);
        @(posedge clk); #1;

        // Wide-output instance: IN_W=12, OUT_W=64, BR_SHIFT=4
        b_lit_valid[1] = 1'b1; b_lit_imm[1] = 64'hFFFF_FFFF_FFFF_8000;
        b_lit_valid[2] = 1'b1; b_lit_imm[2] = 64'hABC0_0000_0000_0000;
        b_if.in_valid = 1'b1; b_if.in_mode = 3'd3; b_if.in_imm = 12'h800; b_if.in_tag = 5'd1;
        @(posedge clk); #1;
        b_if.in_mode = 3'd2; b_if.in_imm = 12'hABC; b_if.in_tag = 5'd2;
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;

        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, registered immediate-extension stage for the pipelined CPU datapath. It takes an IN_W-bit immediate plus a mode code and produces an OUT_W-bit operand one cycle later. Modes cover sign, zero, upper-placement (LUI), branch-offset shift and byte extension. A valid/ready handshake with a one-entry skid buffer lets the stage sit between ID and EX and absorb back-pressure without losing data. A saturating error counter tracks reserved-mode requests.

## Interface
- IN_W, 16, input immediate width; legal range 8..OUT_W
- OUT_W, 32, output operand width; legal range IN_W..64
- BR_SHIFT, 2, left shift applied in branch-offset mode; legal range 0..OUT_W-IN_W
- TAG_W, 5, width of the sideband tag carried alongside the operand (e.g. destination register)
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  upstream has a request
- in_ready  output  1  stage can accept this cycle; equals NOT skid_valid
- in_mode  input  3  extension mode (see Operation)
- in_imm  input  IN_W  raw immediate
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  out_imm, out_tag and out_err hold a result
- out_ready  input  1  downstream consumes this cycle
- out_imm  output  OUT_W  extended operand
- out_tag  output  TAG_W  tag of the result
- out_err  output  1  result came from a reserved mode
- err_cnt  output  8  saturating count of accepted reserved-mode requests

## Operation
- Modes, with S = IN_W-bit in_imm:
  - 0: zero-extend S.
  - 1: sign-extend S.
  - 2: upper placement. S is placed in bits [OUT_W-1:OUT_W-IN_W] and the lower bits are 0. When OUT_W = IN_W, the result is S.
  - 3: sign-extend S, then shift left by BR_SHIFT. The result is truncated to OUT_W bits.
  - 4: sign-extend S[7:0].
  - 5: zero-extend S[7:0].
  - 6 and 7: reserved. out_imm = 0 and out_err = 1.
- Accept condition: transfer in happens when in_valid AND in_ready AND NOT flush.
- Output register (out_imm, out_tag, out_err, out_valid) loads the computed result on accept when the output register is empty or out_ready = 1.
- Skid register:
  - It captures the computed result on accept when out_valid = 1 and out_ready = 0.
  - When out_ready = 1 and skid_valid = 1, skid contents move to the output register, and a simultaneous accept goes into skid. in_ready is 0 whenever skid_valid = 1, so this case cannot occur.
- out_valid clears when out_ready = 1 and nothing new is loaded.
- Ordering is strictly FIFO. No result is dropped or duplicated except on flush.
- flush = 1: at the next edge, out_valid and skid_valid clear and any input offered that cycle is discarded. err_cnt is not affected by discarded inputs.
- err_cnt increments by 1 on every accepted mode 6 or 7 request and saturates at 255. It is cleared only by reset.
- Reset values (asynchronous, immediate on rst_n = 0): out_valid 0, skid_valid 0, in_ready 1, out_imm 0, out_tag 0, out_err 0, err_cnt 0. No transfer is recognised while rst_n = 0.
- Reset deasserted mid-stream: the state is as after a clean reset, and in-flight data is lost.

## Timing
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 result per cycle while out_ready = 1.
- in_ready is a function of registered state only, with no combinational path from out_ready. There is no combinational path from in_* to out_*.
- Stall: with out_ready held 0, the stage accepts exactly 2 requests (output register plus skid), then in_ready = 0.
- out_imm, out_tag and out_err must stay stable while out_valid = 1 and out_ready = 0.
- When out_ready rises after a full stall, the skid entry appears on the outputs at the next edge and in_ready returns to 1 in that same cycle.

## Test plan
- Default params, out_ready = 1, single requests one cycle apart:
  - mode0 0x8001 -> 0x00008001
  - mode1 0x8001 -> 0xFFFF8001
  - mode2 0x1234 -> 0x12340000
  - mode3 0x8001 -> 0xFFFE0004
  - mode4 0x1280 -> 0xFFFFFF80
  - mode5 0x1280 -> 0x00000080
  - each result appears 1 cycle after accept.
- Back-pressure: send tags 1, 2, 3 back-to-back with out_ready = 0 -> tags 1 and 2 held and in_ready = 0. Tag 3 waits upstream. Then release out_ready -> outputs appear in the order 1, 2, 3 with no gaps or loss.
- Reserved modes: 300 accepted mode-6/7 requests -> out_imm = 0 and out_err = 1 on each; err_cnt saturates at 255.
- Flush: with both entries full, assert flush for 1 cycle while in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and the offered request is never output.
- Async reset: assert rst_n = 0 between clock edges during streaming -> all outputs take their reset values immediately. After release, mode1 0x7FFF -> 0x00007FFF.
- Parameter sweep with IN_W = 12, OUT_W = 64, BR_SHIFT = 4: mode3 0x800 -> 0xFFFFFFFFFFFF8000, and mode2 0xABC -> 0xABC0000000000000.
